// File: rtl/dct_2d_pkg.sv
// Shared constants and helpers for the 8x8 forward DCT.
// The cosine table is valid for COEF_FRAC_DFLT only. The top-level macro DCT2D_SAT_EN
// selects clamping, which uses saturate(); without it the output wraps.
package dct_2d_pkg;

   localparam int COEF_FRAC_DFLT = 12;
   localparam int COEF_W         = COEF_FRAC_DFLT + 2;

   typedef logic signed [COEF_W-1:0] coef_t;

   // C[u][x] = round(2^12 * c(u) * cos((2x+1)*u*pi/16)), c(0)=sqrt(1/8), c(u>0)=1/2
   localparam coef_t COEF_TBL [8][8] = '{
      '{ 14'sd1448,  14'sd1448,  14'sd1448,  14'sd1448,  14'sd1448,  14'sd1448,  14'sd1448,  14'sd1448},
      '{ 14'sd2009,  14'sd1703,  14'sd1138,  14'sd400,  -14'sd400,  -14'sd1138, -14'sd1703, -14'sd2009},
      '{ 14'sd1892,  14'sd784,  -14'sd784,  -14'sd1892, -14'sd1892, -14'sd784,   14'sd784,   14'sd1892},
      '{ 14'sd1703, -14'sd400,  -14'sd2009, -14'sd1138,  14'sd1138,  14'sd2009,  14'sd400,  -14'sd1703},
      '{ 14'sd1448, -14'sd1448, -14'sd1448,  14'sd1448,  14'sd1448, -14'sd1448, -14'sd1448,  14'sd1448},
      '{ 14'sd1138, -14'sd2009,  14'sd400,   14'sd1703, -14'sd1703, -14'sd400,   14'sd2009, -14'sd1138},
      '{ 14'sd784,  -14'sd1892,  14'sd1892, -14'sd784,  -14'sd784,   14'sd1892, -14'sd1892,  14'sd784 },
      '{ 14'sd400,  -14'sd1138,  14'sd1703, -14'sd2009,  14'sd2009, -14'sd1703,  14'sd1138, -14'sd400 }
   };

   // Round half up, then arithmetic shift right by sh
   function automatic logic signed [63:0] round_shift(input logic signed [63:0] v, input int sh);
      logic signed [63:0] bias;
      bias = (sh > 0) ? (64'sd1 <<< (sh - 1)) : 64'sd0;
      return (v + bias) >>> sh;
   endfunction

   // Clamp v to the signed n-bit range
   function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int n);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (n - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (n - 1));
      if (v > hi)      return hi;
      else if (v < lo) return lo;
      else             return v;
   endfunction

endpackage

// File: rtl/dct_2d_dct_1d8.sv
// Combinational 8-point 1D DCT: y[u] = sum_x x[x]*C[u][x].
// ACC_W must cover the worst case |x|max * sum|C[u]|; ROUND selects round-half-up
// followed by an arithmetic shift of SHIFT bits before narrowing to OUT_W.
module dct_1d8
   import dct_2d_pkg::*;
#(
   parameter int IN_W  = 10,
   parameter int ACC_W = 26,
   parameter int OUT_W = 26,
   parameter bit ROUND = 1'b0,
   parameter int SHIFT = 0
) (
   input  logic [8*IN_W-1:0]  x_in,
   output logic [8*OUT_W-1:0] y_out
);

   // Eight sign-extended multiply-accumulate sums, one per output frequency
   always_comb begin
      logic signed [ACC_W-1:0] acc;
      logic signed [63:0]      rnd;
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      acc   = '0;
      rnd   = '0;
      y_out = '0;
      for (int u = 0; u < 8; u++) begin
         acc = '0;
         // NOTE: blocking assignments here on purpose: acc is a running sum evaluated in order.
         for (int x = 0; x < 8; x++)
            acc = acc + ACC_W'(signed'(x_in[x*IN_W +: IN_W])) * ACC_W'(COEF_TBL[u][x]);
         if (ROUND) begin
            rnd = round_shift(64'(acc), SHIFT);
            y_out[u*OUT_W +: OUT_W] = OUT_W'(rnd);
         end else begin
            y_out[u*OUT_W +: OUT_W] = OUT_W'(acc);
         end
      end
   end

endmodule

// File: rtl/dct_2d.sv
// Fully pipelined 8x8 orthonormal forward DCT-II, one block per clock, 3-clock latency.
// Stage 1 registers the input, stage 2 the row pass, stage 3 the rounded column pass.
// Define DCT2D_SAT_EN to clamp outputs to N bits; otherwise outputs wrap to N bits.
module dct_2d
   import dct_2d_pkg::*;
#(
   parameter int N         = 10,
   parameter int COEF_FRAC = dct_2d_pkg::COEF_FRAC_DFLT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N*64-1:0] data_in,
   output logic [N*64-1:0] data_out
);

   localparam int BLK_W     = 64 * N;
   localparam int ROW_W     = N + COEF_FRAC + 4;
   localparam int COL_ACC_W = ROW_W + COEF_FRAC + 4;
   localparam int COL_W     = COL_ACC_W - 2 * COEF_FRAC;

   logic [BLK_W-1:0]     data_d, data_q;
   logic [64*ROW_W-1:0]  row_d, row_q;
   logic [8*ROW_W-1:0]   col_vec [8];
   logic [8*COL_W-1:0]   col_y   [8];
   logic [BLK_W-1:0]     dout_d, dout_q;

   // Stage 1 input capture, no handshake
   always_comb data_d = data_in;

   // Row pass: instance m transforms row m (elements m*8..m*8+7 are contiguous)
   for (genvar m = 0; m < 8; m++) begin : g_row
      dct_1d8 #(
         .IN_W  (N),
         .ACC_W (ROW_W),
         .OUT_W (ROW_W),
         .ROUND (1'b0),
         .SHIFT (0)
      ) u_row (
         .x_in  (data_q[m*8*N +: 8*N]),
         .y_out (row_d[m*8*ROW_W +: 8*ROW_W])
      );
   end

   // Transpose: gather column v of the registered row results
   always_comb begin
      for (int v = 0; v < 8; v++) begin
         col_vec[v] = '0;
         for (int m = 0; m < 8; m++)
            col_vec[v][m*ROW_W +: ROW_W] = row_q[(m*8+v)*ROW_W +: ROW_W];
      end
   end

   // Column pass: instance v yields Y[u][v] for u = 0..7, rounded
   for (genvar v = 0; v < 8; v++) begin : g_col
      dct_1d8 #(
         .IN_W  (ROW_W),
         .ACC_W (COL_ACC_W),
         .OUT_W (COL_W),
         .ROUND (1'b1),
         .SHIFT (2 * COEF_FRAC)
      ) u_col (
         .x_in  (col_vec[v]),
         .y_out (col_y[v])
      );
   end

   // Narrow each coefficient to N bits and place it at k = u*8+v
   always_comb begin
      logic signed [COL_W-1:0] col_val;
      col_val = '0;
      dout_d  = '0;
      for (int u = 0; u < 8; u++) begin
         for (int v = 0; v < 8; v++) begin
            col_val = signed'(col_y[v][u*COL_W +: COL_W]);
`ifdef DCT2D_SAT_EN
            dout_d[(u*8+v)*N +: N] = N'(saturate(64'(col_val), N));
`else
            dout_d[(u*8+v)*N +: N] = N'(col_val);
`endif
         end
      end
   end

   // Pipeline registers
   // NOTE: every stage is cleared in reset so no stale block can leak out after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         row_q  <= '0;
         dout_q <= '0;
      end else begin
         data_q <= data_d;
         row_q  <= row_d;
         dout_q <= dout_d;
      end
   end

   assign data_out = dout_q;

endmodule

// File: tb/tb_dct_2d.sv
// Self-checking bench for dct_2d against a floating-point separable DCT-II model.
module tb_dct_2d;

   localparam int  N     = 10;
   localparam int  BLK_W = 64 * N;
   localparam real PI    = 3.14159265358979;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [BLK_W-1:0] data_in = '0;
   logic [BLK_W-1:0] data_out;

   int  n_cmp = 0;
   int  n_bad = 0;
   real ct [8][8];

   dct_2d #(.N(N)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .data_in  (data_in),
      .data_out (data_out)
   );

   always #5 clk = ~clk;

   function automatic int out_el(input int k);
      return int'($signed(data_out[k*N +: N]));
   endfunction

   function automatic logic [BLK_W-1:0] const_blk(input int val);
      logic [BLK_W-1:0] b;
      for (int k = 0; k < 64; k++) b[k*N +: N] = N'(val);
      return b;
   endfunction

   function automatic logic [BLK_W-1:0] rand_blk();
      logic [BLK_W-1:0] b;
      int val;
      for (int k = 0; k < 64; k++) begin
         val = int'($urandom_range(511, 0)) - 256;
         b[k*N +: N] = N'(val);
      end
      return b;
   endfunction

   // Ideal orthonormal 2D DCT-II coefficient k = u*8+v of block b
   function automatic real ref_out(input logic [BLK_W-1:0] b, input int k);
      int  u, v;
      real s;
      u = k / 8;
      v = k % 8;
      s = 0.0;
      for (int m = 0; m < 8; m++)
         for (int x = 0; x < 8; x++)
            s += ct[u][m] * ct[v][x] * real'(int'($signed(b[(m*8+x)*N +: N])));
      return s;
   endfunction

   // Distance between DUT output and ideal value after the N-bit narrowing rule
   function automatic real err_of(input real y, input int act);
      real d;
      real yc;
`ifdef DCT2D_SAT_EN
      yc = y;
      if (yc > 511.0)  yc = 511.0;
      if (yc < -512.0) yc = -512.0;
      d = real'(act) - yc;
`else
      yc = y;
      d = real'(act) - yc;
      while (d > 512.0)  d -= 1024.0;
      while (d < -512.0) d += 1024.0;
`endif
      return (d < 0.0) ? -d : d;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         data_in = rand_blk();
         #1;
         n_cmp++;
         if (data_out !== '0) begin
            n_bad++;
            $display("FAIL reset_hold: data_out=%h, required 0", data_out);
         end
      end
      @(negedge clk);
      rst_n   = 1'b1;
      data_in = rand_blk();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_cmp++;
         if (data_out !== '0) begin
            n_bad++;
            $display("FAIL reset_release edge %0d: data_out=%h, required 0", i + 1, data_out);
         end
         data_in = rand_blk();
      end
   endtask

   task automatic test_zero();
      @(negedge clk);
      data_in = '0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (data_out !== '0) begin
         n_bad++;
         $display("FAIL zero_block: data_out=%h, required 0", data_out);
      end
   endtask

   task automatic test_dc(input string name, input int val, input int exp_dc);
      @(negedge clk);
      data_in = const_blk(val);
      repeat (3) @(negedge clk);
      n_cmp++;
      if (out_el(0) !== exp_dc) begin
         n_bad++;
         $display("FAIL %s dc: got %0d, required %0d", name, out_el(0), exp_dc);
      end
      n_cmp++;
      if (data_out[BLK_W-1:N] !== '0) begin
         n_bad++;
         $display("FAIL %s ac: got %h, required 0", name, data_out[BLK_W-1:N]);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      data_in = '0;
      repeat (3) @(negedge clk);
      data_in = const_blk(50);
      @(negedge clk);
      data_in = const_blk(-50);
      @(negedge clk);
      n_cmp++;
      if (out_el(0) !== 0) begin
         n_bad++;
         $display("FAIL b2b early: got %0d, required 0", out_el(0));
      end
      @(negedge clk);
      n_cmp++;
      if (out_el(0) !== 400) begin
         n_bad++;
         $display("FAIL b2b block_a: got %0d, required 400", out_el(0));
      end
      @(negedge clk);
      n_cmp++;
      if (out_el(0) !== -400) begin
         n_bad++;
         $display("FAIL b2b block_b: got %0d, required -400", out_el(0));
      end
   endtask

   // Random stream, one block per clock; pulse_at >= 0 pulses reset at that iteration
   task automatic test_random(input string name, input int nblk, input int pulse_at);
      logic [BLK_W-1:0] hist [$];
      logic [BLK_W-1:0] b;
      real e;
      int  shown;
      bit  flushed;
      flushed = 1'b0;
      hist.delete();
      for (int i = 0; i < nblk; i++) begin
         @(negedge clk);
         if (i == pulse_at) begin
            rst_n = 1'b0;
            #1;
            n_cmp++;
            if (data_out !== '0) begin
               n_bad++;
               $display("FAIL %s async_clear: data_out=%h, required 0", name, data_out);
            end
            hist.delete();
            flushed = 1'b1;
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
         end
         if (hist.size() == 3) begin
            shown = 0;
            for (int k = 0; k < 64; k++) begin
               e = err_of(ref_out(hist[0], k), out_el(k));
               n_cmp++;
               if (e > 1.0) begin
                  n_bad++;
                  if (shown < 4)
                     $display("FAIL %s blk %0d k %0d: got %0d, required %f +-1",
                              name, i - 3, k, out_el(k), ref_out(hist[0], k));
                  shown++;
               end
            end
            void'(hist.pop_front());
         end else if (flushed) begin
            n_cmp++;
            if (data_out !== '0) begin
               n_bad++;
               $display("FAIL %s refill iter %0d: data_out=%h, required 0", name, i, data_out);
            end
         end
         b       = rand_blk();
         data_in = b;
         hist.push_back(b);
      end
   endtask

   initial begin
      for (int u = 0; u < 8; u++)
         for (int x = 0; x < 8; x++)
            ct[u][x] = ((u == 0) ? $sqrt(0.125) : 0.5) * $cos(real'((2*x+1)*u) * PI / 16.0);

      test_reset();
      test_zero();
      test_dc("dc50", 50, 400);
`ifdef DCT2D_SAT_EN
      test_dc("dc100", 100, 511);
`else
      test_dc("dc100", 100, -224);
`endif
      test_back_to_back();
      test_random("rand", 60, -1);
      test_random("rand_rst", 60, 25);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
